// File: rtl/icc_branch_eval.sv
// icc_branch_eval
//   Holds the architectural integer condition codes, evaluates SPARC Bicc
//   conditions against them and tracks the branch delay slot.
//
//   State table
//     state | meaning
//     IDLE  | no branch outstanding; a presented branch is evaluated and accepted
//     SLOT  | branch accepted; waiting for its delay-slot instruction
//
//   Ports
//     clk        in   rising-edge clock
//     reset      in   synchronous active-high reset (beats stall)
//     alu_flags  in   [3:0] {Z,N,C,V} from the ALU
//     cc_we      in   write alu_flags into icc
//     stall      in   pipeline hold, freezes every register
//     br_valid   in   Bicc presented this cycle
//     br_cond    in   [3:0] Bicc cond field
//     br_annul   in   Bicc a bit
//     slot_valid in   delay-slot instruction presented this cycle
//     icc        out  [3:0] registered {Z,N,C,V}
//     alu_cin    out  icc C bit, ALU carry-in
//     br_taken   out  registered taken pulse, the cycle after acceptance
//     slot_annul out  squash the delay-slot instruction (valid in SLOT)
//     dcti_err   out  sticky: branch seen inside a delay slot

module icc_branch_eval #(
  parameter bit         FORWARD   = 1'b1,
  parameter logic [3:0] ICC_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] alu_flags,
  input  logic       cc_we,
  input  logic       stall,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  input  logic       br_annul,
  input  logic       slot_valid,
  output logic [3:0] icc,
  output logic       alu_cin,
  output logic       br_taken,
  output logic       slot_annul,
  output logic       dcti_err
);

  typedef enum logic {IDLE, SLOT} state_t;

  state_t     state, state_next;
  logic       br_taken_next, slot_annul_next, dcti_err_next;
  logic [3:0] f;
  logic       z, n, c, v;
  logic       cond_base, taken, annul;

  assign alu_cin = icc[1];

  // Forwarding lets a branch issued alongside its cc-setting instruction see
  // the new flags instead of the stale register value.
  assign f = (FORWARD && cc_we) ? alu_flags : icc;
  assign {z, n, c, v} = f;

  // cond[3] inverts the sense of the cond[2:0] test; 1000 is never inverted.
  always_comb begin
    cond_base = 1'b0;
    case (br_cond[2:0])
      3'b000:  cond_base = 1'b0;
      3'b001:  cond_base = z;
      3'b010:  cond_base = z | (n ^ v);
      3'b011:  cond_base = n ^ v;
      3'b100:  cond_base = c | z;
      3'b101:  cond_base = c;
      3'b110:  cond_base = n;
      3'b111:  cond_base = v;
      default: cond_base = 1'b0;
    endcase
  end

  assign taken = cond_base ^ br_cond[3];
  // Branch-always with a=1 annuls its slot even though it is taken.
  assign annul = br_annul & (~taken | (br_cond == 4'b1000));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      icc        <= ICC_RESET;
      br_taken   <= 1'b0;
      slot_annul <= 1'b0;
      dcti_err   <= 1'b0;
    end else if (!stall) begin
      state      <= state_next;
      br_taken   <= br_taken_next;
      slot_annul <= slot_annul_next;
      dcti_err   <= dcti_err_next;
      if (cc_we) icc <= alu_flags;
    end
  end

  always_comb begin
    state_next      = state;
    br_taken_next   = 1'b0;
    slot_annul_next = slot_annul;
    dcti_err_next   = dcti_err;
    case (state)
      IDLE: begin
        if (br_valid) begin
          state_next      = SLOT;
          br_taken_next   = taken;
          slot_annul_next = annul;
        end
      end
      SLOT: begin
        // A branch in the slot is flagged but otherwise ignored.
        if (br_valid) dcti_err_next = 1'b1;
        if (slot_valid) begin
          state_next      = IDLE;
          slot_annul_next = 1'b0;
        end
      end
      default: begin
        state_next      = IDLE;
        slot_annul_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icc_branch_eval.sv
module tb_icc_branch_eval;

  logic       clk = 1'b0;
  logic       reset, cc_we, stall, br_valid, br_annul, slot_valid;
  logic [3:0] alu_flags, br_cond;

  logic [3:0] icc_f, icc_n;
  logic       cin_f, cin_n, tk_f, tk_n, an_f, an_n, de_f, de_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icc_branch_eval #(.FORWARD(1'b1), .ICC_RESET(4'b0000)) dut (
    .clk(clk), .reset(reset), .alu_flags(alu_flags), .cc_we(cc_we),
    .stall(stall), .br_valid(br_valid), .br_cond(br_cond),
    .br_annul(br_annul), .slot_valid(slot_valid),
    .icc(icc_f), .alu_cin(cin_f), .br_taken(tk_f),
    .slot_annul(an_f), .dcti_err(de_f)
  );

  icc_branch_eval #(.FORWARD(1'b0), .ICC_RESET(4'b0000)) dut_nf (
    .clk(clk), .reset(reset), .alu_flags(alu_flags), .cc_we(cc_we),
    .stall(stall), .br_valid(br_valid), .br_cond(br_cond),
    .br_annul(br_annul), .slot_valid(slot_valid),
    .icc(icc_n), .alu_cin(cin_n), .br_taken(tk_n),
    .slot_annul(an_n), .dcti_err(de_n)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // advance one cycle; outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic [3:0] cond, input logic a);
    br_valid = 1'b1; br_cond = cond; br_annul = a;
    tick();
    br_valid = 1'b0; br_cond = 4'b0000; br_annul = 1'b0;
  endtask

  task automatic slot();
    slot_valid = 1'b1;
    tick();
    slot_valid = 1'b0;
  endtask

  task automatic write_cc(input logic [3:0] fl);
    cc_we = 1'b1; alu_flags = fl;
    tick();
    cc_we = 1'b0; alu_flags = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; cc_we = 1'b0; stall = 1'b0; br_valid = 1'b0;
    br_annul = 1'b0; slot_valid = 1'b0; alu_flags = 4'b0000; br_cond = 4'b0000;
    #2;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_icc", icc_f, 4'b0000);
    chk("rst_cin", {3'b0, cin_f}, 4'd0);
    chk("rst_taken", {3'b0, tk_f}, 4'd0);
    chk("rst_annul", {3'b0, an_f}, 4'd0);
    chk("rst_dcti", {3'b0, de_f}, 4'd0);
    chk("rst_icc_nf", icc_n, 4'b0000);

    // icc write and carry feedback, then reset clears it
    write_cc(4'b0010);
    chk("wr_icc", icc_f, 4'b0010);
    chk("wr_cin", {3'b0, cin_f}, 4'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_icc", icc_f, 4'b0000);
    chk("rst2_cin", {3'b0, cin_f}, 4'd0);

    // BE with Z=1, a=0: taken pulse, no annul
    write_cc(4'b1000);
    chk("icc_z", icc_f, 4'b1000);
    branch(4'b0001, 1'b0);
    chk("be_taken", {3'b0, tk_f}, 4'd1);
    chk("be_annul", {3'b0, an_f}, 4'd0);
    tick();
    chk("be_pulse_end", {3'b0, tk_f}, 4'd0);
    slot();
    chk("be_slot_annul", {3'b0, an_f}, 4'd0);

    // BGE with N=1 V=0, a=1: not taken, annul held until slot
    write_cc(4'b0100);
    branch(4'b1011, 1'b1);
    chk("bge_taken", {3'b0, tk_f}, 4'd0);
    chk("bge_annul", {3'b0, an_f}, 4'd1);
    tick();
    chk("bge_annul_hold", {3'b0, an_f}, 4'd1);
    slot();
    chk("bge_annul_clr", {3'b0, an_f}, 4'd0);

    // BA a=1: taken and annulled
    branch(4'b1000, 1'b1);
    chk("ba_taken", {3'b0, tk_f}, 4'd1);
    chk("ba_annul", {3'b0, an_f}, 4'd1);
    slot();
    // BN a=0: nothing
    branch(4'b0000, 1'b0);
    chk("bn_taken", {3'b0, tk_f}, 4'd0);
    chk("bn_annul", {3'b0, an_f}, 4'd0);
    slot();
    // BN a=1: annulled
    branch(4'b0000, 1'b1);
    chk("bn_a_annul", {3'b0, an_f}, 4'd1);
    slot();
    // BLEU with C=1 (icc=0110 would be odd; use 0010): taken
    write_cc(4'b0010);
    branch(4'b0100, 1'b0);
    chk("bleu_taken", {3'b0, tk_f}, 4'd1);
    slot();
    // BCC with C=1: not taken
    branch(4'b1101, 1'b0);
    chk("bcc_taken", {3'b0, tk_f}, 4'd0);
    slot();

    // forwarding: cc_we and branch in the same cycle
    reset = 1'b1; tick(); reset = 1'b0;
    cc_we = 1'b1; alu_flags = 4'b1000;
    branch(4'b0001, 1'b0);
    cc_we = 1'b0; alu_flags = 4'b0000;
    chk("fwd1_taken", {3'b0, tk_f}, 4'd1);
    chk("fwd0_taken", {3'b0, tk_n}, 4'd0);
    chk("fwd1_icc", icc_f, 4'b1000);
    chk("fwd0_icc", icc_n, 4'b1000);
    slot();

    // branch in delay slot, then stall freeze
    branch(4'b1001, 1'b1);           // BNE, Z=1: not taken, annul
    chk("bne_annul", {3'b0, an_f}, 4'd1);
    chk("dcti_pre", {3'b0, de_f}, 4'd0);
    branch(4'b1000, 1'b0);           // branch inside slot
    chk("dcti_set", {3'b0, de_f}, 4'd1);
    chk("dcti_annul_kept", {3'b0, an_f}, 4'd1);
    chk("dcti_no_taken", {3'b0, tk_f}, 4'd0);
    stall = 1'b1; cc_we = 1'b1; alu_flags = 4'b0001; slot_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_icc", icc_f, 4'b1000);
      chk("stall_annul", {3'b0, an_f}, 4'd1);
    end
    stall = 1'b0; cc_we = 1'b0; alu_flags = 4'b0000; slot_valid = 1'b0;
    tick();
    chk("post_stall_slot", {3'b0, an_f}, 4'd1);
    slot();
    chk("slot_exit_annul", {3'b0, an_f}, 4'd0);
    chk("dcti_sticky", {3'b0, de_f}, 4'd1);
    tick();
    chk("dcti_sticky2", {3'b0, de_f}, 4'd1);

    // br_taken stretches under stall
    branch(4'b1000, 1'b0);
    chk("str_taken", {3'b0, tk_f}, 4'd1);
    stall = 1'b1; tick();
    chk("str_taken_held", {3'b0, tk_f}, 4'd1);
    stall = 1'b0;
    slot();
    chk("str_taken_end", {3'b0, tk_f}, 4'd0);

    // reset in SLOT (while stalled) drops the annul decision
    branch(4'b1001, 1'b1);
    chk("rslot_annul", {3'b0, an_f}, 4'd1);
    reset = 1'b1; stall = 1'b1; tick(); reset = 1'b0; stall = 1'b0;
    chk("rslot_annul_clr", {3'b0, an_f}, 4'd0);
    chk("rslot_dcti_clr", {3'b0, de_f}, 4'd0);
    chk("rslot_icc", icc_f, 4'b0000);
    branch(4'b1000, 1'b0);           // accepted only if back in IDLE
    chk("rslot_idle_taken", {3'b0, tk_f}, 4'd1);
    chk("rslot_idle_dcti", {3'b0, de_f}, 4'd0);
    slot();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icc_branch_eval.md
Name: icc_branch_eval

Overview:
- Consumer end of the ALU flag interface.
- Latches the 4-bit {Z,N,C,V} flags from the mini ALU into an architectural integer condition-code register (icc) when an instruction that sets condition codes retires.
- Feeds icc.C back to the ALU carry-in.
- Evaluates the SPARC Bicc condition and tracks the delay slot with a small state machine, producing branch-taken and delay-slot-annul decisions for the fetch/decode stage.

Parameters:
- FORWARD, 1: when 1, a branch evaluated in the same cycle as cc_we uses the incoming alu_flags; when 0, it uses the registered icc.
- ICC_RESET, 4'b0000: reset value of the icc register, ordered {Z,N,C,V}.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- alu_flags  input  4  {Z,N,C,V} from the ALU flags output
- cc_we  input  1  write alu_flags into icc at this edge
- stall  input  1  pipeline hold; freezes icc, the FSM and all registered outputs
- br_valid  input  1  a Bicc instruction is presented this cycle
- br_cond  input  4  Bicc cond field, instruction bits 28:25
- br_annul  input  1  Bicc a bit, instruction bit 29
- slot_valid  input  1  the delay-slot instruction is presented this cycle
- icc  output  4  registered {Z,N,C,V}
- alu_cin  output  1  equals icc[1] (the C bit); drives the ALU cin
- br_taken  output  1  registered one-cycle pulse: branch taken
- slot_annul  output  1  high while in SLOT and the delay-slot instruction must be squashed
- dcti_err  output  1  sticky flag: branch presented inside a delay slot

Behaviour:
- Reset, synchronous and active-high, takes priority over every other input including stall:
  - icc=ICC_RESET, br_taken=0, slot_annul=0, dcti_err=0, state=IDLE.
  - Reset asserted mid-SLOT discards the pending annul decision.
- icc update:
  - At a clock edge with cc_we=1 and stall=0, icc <= alu_flags.
  - Otherwise icc holds.
  - Latency from cc_we to the icc output is 1 cycle.
  - alu_cin is combinational from the icc register.
- Condition evaluation: combinational on the source flags, written f below.
  - f = alu_flags when FORWARD=1 and cc_we=1; otherwise f = icc.
  - With {Z,N,C,V}=f:
    - 1000 always; 0000 never
    - 1001 ~Z; 0001 Z
    - 1010 ~(Z|(N^V)); 0010 Z|(N^V)
    - 1011 ~(N^V); 0011 N^V
    - 1100 ~(C|Z); 0100 C|Z
    - 1101 ~C; 0101 C
    - 1110 ~N; 0110 N
    - 1111 ~V; 0111 V
  - Annul decision: annul = br_annul & (~taken | (br_cond==4'b1000)).
    - Branch-always with a=1 annuls its slot.
    - Branch-never with a=1 annuls its slot.
- FSM, two states:
  - IDLE: when br_valid=1 and stall=0, go to SLOT; br_taken<=taken for one cycle; slot_annul<=annul.
  - SLOT: slot_annul holds its value. When slot_valid=1 and stall=0, go to IDLE and clear slot_annul. br_taken is 0 in SLOT.
- br_taken timing: a 1-cycle pulse in the cycle after acceptance. Under stall it stretches, held until the stall clears.
- Branch in delay slot: br_valid=1 in SLOT with stall=0 sets dcti_err=1.
  - The branch is otherwise ignored: no new evaluation, slot_annul unchanged.
  - If slot_valid is also 1 that cycle, the FSM still returns to IDLE.
  - dcti_err clears only on reset.
- Simultaneous events:
  - cc_we and br_valid in the same IDLE cycle: icc updates, and evaluation follows the FORWARD rule.
  - slot_valid in IDLE is ignored.
- stall=1: no state, icc or output register changes. cc_we and br_valid are dropped that cycle; the issuing stage re-presents them.
- All registered outputs are unknown-free after the first reset edge.

Test Plan:
- Reset, then cc_we=1 with alu_flags=4'b0010 → icc=4'b0010 and alu_cin=1 next cycle; reset asserted → icc=0, alu_cin=0.
- icc=4'b1000 (Z=1), br_valid with cond=0001 (BE), a=0 → br_taken pulses 1 for one cycle, slot_annul=0; slot_valid returns the FSM to IDLE.
- icc=4'b0100 (N=1, V=0), cond=1011 (BGE), a=1 → br_taken=0, slot_annul=1 until slot_valid, then 0.
- cond=1000 (BA), a=1 → br_taken=1, slot_annul=1. Also cond=0000 (BN), a=0 → br_taken=0, slot_annul=0.
- FORWARD=1: icc=0 while cc_we=1 with alu_flags=4'b1000 and br_valid cond=0001 in the same cycle → br_taken=1. With FORWARD=0, the same stimulus → br_taken=0.
- In SLOT, br_valid=1 → dcti_err=1 and stays 1 after return to IDLE. Stall held for 3 cycles in SLOT → state, icc and slot_annul are frozen. Reset in SLOT → IDLE, slot_annul=0.
